// File: rtl/cla_pipe_addsub_pkg.sv
// -----------------------------------------------------------------------------
// cla_pipe_addsub_pkg
// Shared ALU definitions for the pipelined carry-lookahead adder/subtractor:
// operation encodings, NZCV flag bit positions and the operand-prep helpers
// that turn an opcode into "invert B" and "carry into bit 0".
// -----------------------------------------------------------------------------
package cla_pipe_addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;  // A + B
    localparam logic [1:0] OP_SUB = 2'b01;  // A + ~B + 1
    localparam logic [1:0] OP_ADC = 2'b10;  // A + B + cin
    localparam logic [1:0] OP_SBC = 2'b11;  // A + ~B + cin

    // Bit positions inside the 4-bit {N,Z,C,V} flags word.
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // Subtract-style operations add the one's complement of B.
    function automatic logic op_inverts_b(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

    // Carry into bit 0: fixed for ADD/SUB, external cin for ADC/SBC.
    function automatic logic op_carry_in(input logic [1:0] op, input logic cin);
        logic c0;
        case (op)
            OP_ADD:  c0 = 1'b0;
            OP_SUB:  c0 = 1'b1;
            default: c0 = cin;
        endcase
        return c0;
    endfunction

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// -----------------------------------------------------------------------------
// cla_pipe_addsub_if
// Operand and result handshake bundle for cla_pipe_addsub.
//   in_valid/in_ready   : operand channel handshake (accept on both high)
//   op, cin, a, b       : operation, carry-in and operands
//   out_valid/out_ready : result channel handshake (drain on both high)
//   sum, flags          : result and {N,Z,C,V}
// master = operand producer / result consumer, slave = the adder.
// -----------------------------------------------------------------------------
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic [3:0]       flags;

    modport master (
        output in_valid, op, cin, a, b, out_ready,
        input  in_ready, out_valid, sum, flags
    );

    modport slave (
        input  in_valid, op, cin, a, b, out_ready,
        output in_ready, out_valid, sum, flags
    );
endinterface

// File: rtl/cla_pipe_addsub_gp.sv
// -----------------------------------------------------------------------------
// cla_block_gp
// Combinational BLOCK-bit carry-lookahead block. Bit generate/propagate terms
// are merged by a log2(BLOCK)-level prefix tree of gp-combine cells, giving the
// group G/P ending at every bit; each internal carry is then G | P & cin.
// Ports:
//   i_a, i_b  : BLOCK-bit operand slices
//   i_cin     : carry into the block
//   o_sum     : BLOCK-bit sum slice
//   o_g, o_p  : block generate / propagate (independent of i_cin)
//   o_cout    : carry out of the block
//   o_cmsb    : carry into the block's most significant bit
// -----------------------------------------------------------------------------
module cla_block_gp #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    input  logic             i_cin,
    output logic [BLOCK-1:0] o_sum,
    output logic             o_g,
    output logic             o_p,
    output logic             o_cout,
    output logic             o_cmsb
);
    localparam int LV = $clog2(BLOCK);

    // Level l holds the group G/P spanning bits [i-2^l+1 : i] (clipped at bit 0).
    logic [LV:0][BLOCK-1:0] w_g;
    logic [LV:0][BLOCK-1:0] w_p;
    logic [BLOCK:0]         w_c;

    assign w_g[0] = i_a & i_b;
    assign w_p[0] = i_a ^ i_b;

    for (genvar l = 0; l < LV; l++) begin : g_lvl
        for (genvar i = 0; i < BLOCK; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_cmb
                assign w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][i-(1<<l)]);
                assign w_p[l+1][i] = w_p[l][i] & w_p[l][i-(1<<l)];
            end else begin : g_pass
                assign w_g[l+1][i] = w_g[l][i];
                assign w_p[l+1][i] = w_p[l][i];
            end
        end
    end

    assign w_c[0] = i_cin;
    for (genvar i = 0; i < BLOCK; i++) begin : g_carry
        assign w_c[i+1] = w_g[LV][i] | (w_p[LV][i] & i_cin);
    end

    assign o_sum  = w_p[0] ^ w_c[BLOCK-1:0];
    assign o_g    = w_g[LV][BLOCK-1];
    assign o_p    = w_p[LV][BLOCK-1];
    assign o_cout = w_c[BLOCK];
    assign o_cmsb = w_c[BLOCK-1];
endmodule

// File: rtl/cla_pipe_addsub.sv
// -----------------------------------------------------------------------------
// cla_pipe_addsub
// Pipelined carry-lookahead adder/subtractor with NZCV flags. The WIDTH-bit
// operation is cut into NBLK = WIDTH/BLOCK lookahead blocks; rank k of the
// pipeline holds the carry c_k, the operand slices not yet consumed (skew)
// and the sum slices already produced (de-skew). A result reaches the output
// registers NBLK cycles after accept; throughput is one op per cycle.
// The whole pipeline advances on en = !out_valid || out_ready.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset (clears valids, sum and flags)
//   bus : cla_pipe_addsub_if slave (operands in, result + {N,Z,C,V} out)
// -----------------------------------------------------------------------------
module cla_pipe_addsub
    import cla_pipe_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic               clk,
    input  logic               rst,
    cla_pipe_addsub_if.slave   bus
);
    localparam int NBLK = WIDTH / BLOCK;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic [3:0]       r_flags;

    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    assign w_en         = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    assign w_b_eff = op_inverts_b(bus.op) ? ~bus.b : bus.b;
    assign w_c0    = op_carry_in(bus.op, bus.cin);

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        // Operand bits still to be consumed by this and later stages.
        localparam int OPW = WIDTH - k * BLOCK;

        logic [OPW-1:0]           r_a;
        logic [OPW-1:0]           r_b;
        logic                     r_c;      // carry into this block
        logic                     r_z;      // all lower blocks were zero
        logic                     r_v;
        logic [BLOCK-1:0]         w_sum;
        logic                     w_cout;
        logic                     w_cmsb;
        logic                     w_g;
        logic                     w_p;
        logic                     w_zero;
        logic                     w_unused_gp;
        logic [(k+1)*BLOCK-1:0]   w_s_nx;   // sum slices handed to the next rank

        if (k == 0) begin : g_load0
            // Rank 0: prepared operands captured at accept.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)       r_v <= 1'b0;
                else if (w_en) r_v <= bus.in_valid;
            end

            always_ff @(posedge clk) begin
                if (w_en) begin
                    r_a <= bus.a;
                    r_b <= w_b_eff;
                    r_c <= w_c0;
                    r_z <= 1'b1;
                end
            end

            assign w_s_nx = w_sum;
        end else begin : g_loadk
            logic [k*BLOCK-1:0] r_s;

            // Rank k: upper operand slices, carry and completed sum from rank k-1.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)       r_v <= 1'b0;
                else if (w_en) r_v <= g_stg[k-1].r_v;
            end

            always_ff @(posedge clk) begin
                if (w_en) begin
                    r_a <= g_stg[k-1].r_a[OPW+BLOCK-1:BLOCK];
                    r_b <= g_stg[k-1].r_b[OPW+BLOCK-1:BLOCK];
                    r_c <= g_stg[k-1].w_cout;
                    r_z <= g_stg[k-1].r_z & g_stg[k-1].w_zero;
                    r_s <= g_stg[k-1].w_s_nx;
                end
            end

            assign w_s_nx = {w_sum, r_s};
        end

        cla_block_gp #(.BLOCK(BLOCK)) u_blk (
            .i_a    (r_a[BLOCK-1:0]),
            .i_b    (r_b[BLOCK-1:0]),
            .i_cin  (r_c),
            .o_sum  (w_sum),
            .o_g    (w_g),
            .o_p    (w_p),
            .o_cout (w_cout),
            .o_cmsb (w_cmsb)
        );

        assign w_zero      = (w_sum == '0);
        // Block G/P are exported for lookahead reuse; the chain here uses cout.
        assign w_unused_gp = w_g & w_p;
    end

    logic [WIDTH-1:0] w_last_s;
    logic             w_last_v;
    logic             w_last_z;
    logic             w_last_c;
    logic             w_last_cmsb;

    assign w_last_s    = g_stg[NBLK-1].w_s_nx;
    assign w_last_v    = g_stg[NBLK-1].r_v;
    assign w_last_z    = g_stg[NBLK-1].r_z & g_stg[NBLK-1].w_zero;
    assign w_last_c    = g_stg[NBLK-1].w_cout;
    assign w_last_cmsb = g_stg[NBLK-1].w_cmsb;

    // Output rank: loaded only by a valid entry, so bubbles leave the last
    // result in place, and nothing moves while a result is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_flags     <= '0;
        end else if (w_en) begin
            r_out_valid <= w_last_v;
            if (w_last_v) begin
                r_sum          <= w_last_s;
                r_flags[FLG_N] <= w_last_s[WIDTH-1];
                r_flags[FLG_Z] <= w_last_z;
                r_flags[FLG_C] <= w_last_c;
                // Signed overflow: carry into the MSB differs from carry out.
                r_flags[FLG_V] <= w_last_c ^ w_last_cmsb;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.flags     = r_flags;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_addsub
// Self-checking bench for cla_pipe_addsub (WIDTH=32, BLOCK=8). Expected results
// come from a plain-arithmetic model of the ADD/SUB/ADC/SBC rules and NZCV.
// -----------------------------------------------------------------------------
module tb_cla_pipe_addsub;
    import cla_pipe_addsub_pkg::*;

    localparam int W   = 32;
    localparam int BLK = 8;
    localparam int NB  = W / BLK;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.WIDTH(W)) bus_if ();

    cla_pipe_addsub #(.WIDTH(W), .BLOCK(BLK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: {sum, N, Z, C, V}
    function automatic logic [W+3:0] ref_model(input logic [1:0] op, input logic cin,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] bo;
        logic         c0;
        logic [W:0]   wide;
        logic [W-1:0] s;
        logic         n, z, c, v;
        case (op)
            OP_ADD:  begin bo = b;  c0 = 1'b0; end
            OP_SUB:  begin bo = ~b; c0 = 1'b1; end
            OP_ADC:  begin bo = b;  c0 = cin;  end
            default: begin bo = ~b; c0 = cin;  end
        endcase
        wide = {1'b0, a} + {1'b0, bo} + {{W{1'b0}}, c0};
        s = wide[W-1:0];
        c = wide[W];
        n = s[W-1];
        z = (s == '0);
        v = (a[W-1] == bo[W-1]) && (s[W-1] != a[W-1]);
        return {s, n, z, c, v};
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] x;
        case ($urandom_range(0, 7))
            0:       x = '0;
            1:       x = '1;
            2:       x = 32'h8000_0000;
            3:       x = 32'h7FFF_FFFF;
            default: x = $urandom;
        endcase
        return x;
    endfunction

    task automatic idle_inputs();
        bus_if.in_valid  = 1'b0;
        bus_if.op        = OP_ADD;
        bus_if.cin       = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus_if.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus_if.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid);
        end
        n_cmp++;
        if (bus_if.sum !== '0) begin
            n_bad++; $display("FAIL reset_sum: got %h want 0", bus_if.sum);
        end
        n_cmp++;
        if (bus_if.flags !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", bus_if.flags);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus_if.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus_if.in_ready);
        end
        @(posedge clk); #1;
    endtask

    // One isolated op: checks latency, result, flags and a single-cycle out_valid.
    task automatic test_single_op(input string name, input logic [1:0] op, input logic cin,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] exp_sum, input logic [3:0] exp_flags);
        int   lat;
        logic seen;
        bus_if.op = op; bus_if.cin = cin; bus_if.a = a; bus_if.b = b;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus_if.out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || lat != NB) begin
            n_bad++; $display("FAIL %s_latency: got %0d cycles (seen=%b) want %0d", name, lat, seen, NB);
        end
        n_cmp++;
        if (bus_if.sum !== exp_sum) begin
            n_bad++; $display("FAIL %s_sum: got %h want %h", name, bus_if.sum, exp_sum);
        end
        n_cmp++;
        if (bus_if.flags !== exp_flags) begin
            n_bad++; $display("FAIL %s_flags: got %b want %b", name, bus_if.flags, exp_flags);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus_if.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL %s_pulse: out_valid got %b want 0", name, bus_if.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 12;
        logic [W+3:0] q[$];
        logic [W+3:0] exp;
        logic [W-1:0] held_sum;
        logic [3:0]   held_flags;
        logic         stall_prev = 1'b0;
        int sent = 0, drained = 0, cyc = 0, low_rdy = 0;
        while (drained < N && cyc < 200) begin
            bus_if.in_valid = (sent < N);
            bus_if.op  = 2'(sent % 4);
            bus_if.cin = sent[0];
            bus_if.a   = 32'h0101_0101 * sent + 32'h00FF_00FF;
            bus_if.b   = 32'h1234_5678 ^ (32'h0F0F_0F0F * sent);
            bus_if.out_ready = !(cyc >= 6 && cyc < 9);
            @(negedge clk);
            n_cmp++;
            if (bus_if.in_ready !== (!bus_if.out_valid || bus_if.out_ready)) begin
                n_bad++; $display("FAIL b2b_in_ready cyc %0d: got %b out_valid=%b out_ready=%b",
                                  cyc, bus_if.in_ready, bus_if.out_valid, bus_if.out_ready);
            end
            if (bus_if.in_ready === 1'b0) low_rdy++;
            if (stall_prev) begin
                n_cmp++;
                if (bus_if.out_valid !== 1'b1 || bus_if.sum !== held_sum || bus_if.flags !== held_flags) begin
                    n_bad++; $display("FAIL b2b_stall_hold: got v=%b %h/%b want v=1 %h/%b",
                                      bus_if.out_valid, bus_if.sum, bus_if.flags, held_sum, held_flags);
                end
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra_result: got %h want none", bus_if.sum);
                end else begin
                    exp = q.pop_front();
                    if ({bus_if.sum, bus_if.flags} !== exp) begin
                        n_bad++; $display("FAIL b2b_result %0d: got %h/%b want %h/%b",
                                          drained, bus_if.sum, bus_if.flags, exp[W+3:4], exp[3:0]);
                    end
                end
                drained++;
            end
            if (bus_if.in_valid && bus_if.in_ready) begin
                q.push_back(ref_model(bus_if.op, bus_if.cin, bus_if.a, bus_if.b));
                sent++;
            end
            stall_prev = bus_if.out_valid && !bus_if.out_ready;
            held_sum   = bus_if.sum;
            held_flags = bus_if.flags;
            @(posedge clk); #1;
            cyc++;
        end
        idle_inputs();
        n_cmp++;
        if (drained != N || q.size() != 0) begin
            n_bad++; $display("FAIL b2b_count: got %0d drained, %0d pending want %0d, 0", drained, q.size(), N);
        end
        n_cmp++;
        if (low_rdy != 3) begin
            n_bad++; $display("FAIL b2b_in_ready_low_cycles: got %0d want 3", low_rdy);
        end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.op = OP_ADD;
            bus_if.a = 32'h1000 + i;
            bus_if.b = 32'h1;
            @(posedge clk); #1;
        end
        bus_if.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus_if.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL midrst_out_valid: got %b want 0", bus_if.out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3 * NB; i++) begin
            @(negedge clk);
            if (bus_if.out_valid !== 1'b0) stale++;
        end
        n_cmp++;
        if (stale != 0) begin
            n_bad++; $display("FAIL midrst_stale: got %0d valid cycles want 0", stale);
        end
        n_cmp++;
        if (bus_if.sum !== '0) begin
            n_bad++; $display("FAIL midrst_sum: got %h want 0", bus_if.sum);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        localparam int N = 10000;
        logic [W+3:0] q[$];
        logic [W+3:0] exp;
        logic [W-1:0] held_sum;
        logic [3:0]   held_flags;
        logic         stall_prev = 1'b0;
        int sent = 0, drained = 0, cyc = 0;
        while (drained < N && cyc < 60000) begin
            if (!bus_if.in_valid && sent < N && $urandom_range(0, 3) != 0) begin
                bus_if.in_valid = 1'b1;
                bus_if.op  = 2'($urandom_range(0, 3));
                bus_if.cin = 1'($urandom_range(0, 1));
                bus_if.a   = rand_word();
                bus_if.b   = rand_word();
            end
            bus_if.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (stall_prev) begin
                n_cmp++;
                if (bus_if.out_valid !== 1'b1 || bus_if.sum !== held_sum || bus_if.flags !== held_flags) begin
                    n_bad++; $display("FAIL rnd_stall_hold cyc %0d: got v=%b %h/%b want v=1 %h/%b", cyc,
                                      bus_if.out_valid, bus_if.sum, bus_if.flags, held_sum, held_flags);
                end
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL rnd_extra_result: got %h want none", bus_if.sum);
                end else begin
                    exp = q.pop_front();
                    if ({bus_if.sum, bus_if.flags} !== exp) begin
                        n_bad++; $display("FAIL rnd_result %0d: got %h/%b want %h/%b",
                                          drained, bus_if.sum, bus_if.flags, exp[W+3:4], exp[3:0]);
                    end
                end
                drained++;
            end
            stall_prev = bus_if.out_valid && !bus_if.out_ready;
            held_sum   = bus_if.sum;
            held_flags = bus_if.flags;
            @(posedge clk);
            if (bus_if.in_valid && bus_if.in_ready) begin
                q.push_back(ref_model(bus_if.op, bus_if.cin, bus_if.a, bus_if.b));
                sent++;
                #1 bus_if.in_valid = 1'b0;
            end else begin
                #1;
            end
            cyc++;
        end
        idle_inputs();
        n_cmp++;
        if (drained != N || q.size() != 0) begin
            n_bad++; $display("FAIL rnd_count: got %0d drained, %0d pending want %0d, 0", drained, q.size(), N);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_single_op("add_1_1",     OP_ADD, 1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0000);
        test_single_op("add_wrap",    OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
        test_single_op("add_ovf",     OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
        test_single_op("sub_5_7",     OP_SUB, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b1000);
        test_single_op("sub_7_7",     OP_SUB, 1'b1, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 4'b0110);
        test_single_op("sbc_7_7_c0",  OP_SBC, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'hFFFF_FFFF, 4'b1000);
        test_single_op("adc_1_1_c1",  OP_ADC, 1'b1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 4'b0000);
        test_single_op("sub_min_1",   OP_SUB, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011);
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
